// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock/tick divider. Each channel has a
// shadowed period/high-time so reconfiguration only takes effect on a wrap.
module clk_div_multi #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 27,
  parameter int REF_HZ       = 100_000_000,
  parameter int DEFAULT_FREQ = 1,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_period,
  input  logic [CNT_W-1:0]    wr_high,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending,
  output logic                cfg_err
);

  localparam logic [CNT_W-1:0] P_RST  = CNT_W'(REF_HZ / DEFAULT_FREQ);
  localparam logic [CNT_W-1:0] H_RST  = P_RST >> 1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
  localparam logic [CH_W:0]    CH_LIM = (CH_W+1)'(CHANNELS);

  logic [CNT_W-1:0] per_q  [CHANNELS];
  logic [CNT_W-1:0] per_d  [CHANNELS];
  logic [CNT_W-1:0] hi_q   [CHANNELS];
  logic [CNT_W-1:0] hi_d   [CHANNELS];
  logic [CNT_W-1:0] sper_q [CHANNELS];
  logic [CNT_W-1:0] sper_d [CHANNELS];
  logic [CNT_W-1:0] shi_q  [CHANNELS];
  logic [CNT_W-1:0] shi_d  [CHANNELS];
  logic [CNT_W-1:0] cnt_q  [CHANNELS];
  logic [CNT_W-1:0] cnt_d  [CHANNELS];

  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic                cfg_err_q, cfg_err_d;

  logic                wr_ok;
  logic [CHANNELS-1:0] wr_hit;

  // A write must target an existing channel and describe a real square wave:
  // at least one high and one low cycle per period.
  assign wr_ok = ({1'b0, wr_ch} < CH_LIM) &&
                 (wr_period >= TWO) &&
                 (wr_high != '0) &&
                 (wr_high < wr_period);

  assign cfg_err_d = wr_en && !wr_ok;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_en && wr_ok && (wr_ch == CH_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
      per_d[i]  = per_q[i];
      hi_d[i]   = hi_q[i];
      sper_d[i] = sper_q[i];
      shi_d[i]  = shi_q[i];
      cnt_d[i]  = cnt_q[i];
      pend_d[i] = pend_q[i];
      out_d[i]  = 1'b0;
      tick_d[i] = 1'b0;

      if (ch_en[i]) begin
        if ((cnt_q[i] == per_q[i] - ONE) || sync) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          out_d[i]  = 1'b1;
          if (pend_q[i]) begin
            per_d[i]  = sper_q[i];
            hi_d[i]   = shi_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
          out_d[i] = (cnt_q[i] + ONE) < hi_q[i];
        end
      end else if (pend_q[i] && !wr_hit[i]) begin
        // Re-arm against the period being applied so the first enabled cycle still wraps.
        per_d[i]  = sper_q[i];
        hi_d[i]   = shi_q[i];
        pend_d[i] = 1'b0;
        cnt_d[i]  = sper_q[i] - ONE;
      end else begin
        cnt_d[i] = per_q[i] - ONE;
      end

      // A write only ever touches the shadow; it overrides any pend clear above.
      if (wr_hit[i]) begin
        sper_d[i] = wr_period;
        shi_d[i]  = wr_high;
        pend_d[i] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-channel config arrays are reset because the power-up rate is a defined output.
      for (int i = 0; i < CHANNELS; i++) begin
        per_q[i]  <= P_RST;
        hi_q[i]   <= H_RST;
        sper_q[i] <= P_RST;
        shi_q[i]  <= H_RST;
        cnt_q[i]  <= P_RST - ONE;
      end
      pend_q    <= '0;
      out_q     <= '0;
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      per_q     <= per_d;
      hi_q      <= hi_d;
      sper_q    <= sper_d;
      shi_q     <= shi_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign clk_out = out_q;
  assign tick    = tick_q;
  assign pending = pend_q;
  assign cfg_err = cfg_err_q;

endmodule
